// File: rtl/instr_word_encoder.sv
// Program loader: encodes symbolic MIPS instruction requests into 32-bit words.
// Words pass through a small FIFO and are written sequentially to instruction memory.
module instr_word_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_kind_i,
    input  logic [4:0]        req_rs_i,
    input  logic [4:0]        req_rt_i,
    input  logic [4:0]        req_rd_i,
    input  logic [4:0]        req_shamt_i,
    input  logic [5:0]        req_funct_i,
    input  logic [15:0]       req_imm_i,
    input  logic [25:0]       req_target_i,
    input  logic              req_last_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       word_count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_ADDI = 3'd1;
    localparam logic [2:0] KIND_SLTI = 3'd2;
    localparam logic [2:0] KIND_BEQ  = 3'd3;
    localparam logic [2:0] KIND_LW   = 3'd4;
    localparam logic [2:0] KIND_SW   = 3'd5;
    localparam logic [2:0] KIND_J    = 3'd6;
    localparam logic [2:0] KIND_JAL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [PTR_W:0]    wr_ptr_reg;
    logic [PTR_W:0]    rd_ptr_reg;
    logic              last_seen_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [15:0]       count_reg;

    logic [5:0]        opcode;
    logic [31:0]       enc_word;
    logic [DEPTH-1:0][32:0] entry_vec;
    logic [32:0]       head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;

    always_comb begin
        opcode = 6'h00;
        case (req_kind_i)
            KIND_R:    opcode = 6'h00;
            KIND_ADDI: opcode = 6'h08;
            KIND_SLTI: opcode = 6'h0A;
            KIND_BEQ:  opcode = 6'h04;
            KIND_LW:   opcode = 6'h23;
            KIND_SW:   opcode = 6'h2B;
            KIND_J:    opcode = 6'h02;
            KIND_JAL:  opcode = 6'h03;
            default:   opcode = 6'h00;
        endcase
    end

    always_comb begin
        enc_word = {opcode, req_rs_i, req_rt_i, req_imm_i};
        case (req_kind_i)
            KIND_R:          enc_word = {opcode, req_rs_i, req_rt_i, req_rd_i, req_shamt_i, req_funct_i};
            KIND_J, KIND_JAL: enc_word = {opcode, req_target_i};
            default:         enc_word = {opcode, req_rs_i, req_rt_i, req_imm_i};
        endcase
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    assign req_ready_o = (state_reg == LOAD) && !fifo_full && !last_seen_reg;
    assign push        = req_valid_i && req_ready_o;

    assign head     = entry_vec[rd_ptr_reg[PTR_W-1:0]];
    assign mem_we_o = !fifo_empty && ((state_reg == LOAD) || (state_reg == DRAIN));
    assign pop      = mem_we_o && mem_ready_i;

    // Data is gated so the bus reads zero whenever no write is offered.
    assign mem_data_o   = mem_we_o ? head[31:0] : 32'h0;
    assign mem_addr_o   = addr_reg;
    assign busy_o       = (state_reg != IDLE);
    assign done_o       = (state_reg == DONE);
    assign word_count_o = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [32:0] data_reg;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi))) begin
                    data_reg <= {req_last_i, enc_word};
                end
            end

            assign entry_vec[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            last_seen_reg <= 1'b0;
            addr_reg      <= '0;
            count_reg     <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                addr_reg   <= addr_reg + ADDR_W'(4);
                if (count_reg != 16'hFFFF) begin
                    count_reg <= count_reg + 16'd1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_reg     <= LOAD;
                        addr_reg      <= base_addr_i & ~ADDR_W'(3);
                        count_reg     <= '0;
                        last_seen_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    if (push && req_last_i) begin
                        last_seen_reg <= 1'b1;
                        state_reg     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && head[32]) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder: hand-encoded MIPS words, write-port
// monitor, backpressure, address wrap, protocol edges and asynchronous reset.
module tb_instr_word_encoder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_kind_i = '0;
    logic [4:0]  req_rs_i = '0;
    logic [4:0]  req_rt_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic [4:0]  req_shamt_i = '0;
    logic [5:0]  req_funct_i = '0;
    logic [15:0] req_imm_i = '0;
    logic [25:0] req_target_i = '0;
    logic        req_last_i = 1'b0;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_ready_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [15:0] word_count_o;

    instr_word_encoder #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_kind_i(req_kind_i),
        .req_rs_i(req_rs_i), .req_rt_i(req_rt_i), .req_rd_i(req_rd_i),
        .req_shamt_i(req_shamt_i), .req_funct_i(req_funct_i), .req_imm_i(req_imm_i),
        .req_target_i(req_target_i), .req_last_i(req_last_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
        .busy_o(busy_o), .done_o(done_o), .word_count_o(word_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tg;
        logic [31:0] word;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] mon_addr[$];
    logic [31:0] mon_data[$];
    int          n_vec = 0;
    int          n_err = 0;

    always @(negedge clk_i) begin
        if (rst_i && mem_we_o && mem_ready_i) begin
            mon_addr.push_back(mem_addr_o);
            mon_data.push_back(mem_data_o);
            $display("write addr=%08h data=%08h", mem_addr_o, mem_data_o);
        end
    end

    function automatic vec_t mk(logic [2:0] k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [4:0] sh, logic [5:0] fn, logic [15:0] imm,
                                logic [25:0] tg, logic [31:0] word);
        vec_t v;
        v.kind = k; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh;
        v.fn = fn; v.imm = imm; v.tg = tg; v.word = word;
        return v;
    endfunction

    // Fields a format does not use are filled with junk so leakage shows up.
    task automatic init_vecs();
        vecs[0]  = mk(3'd1,  1,  2, 31, 31, 6'h3F, 16'h0005, 26'h2AAAAAA, 32'h20220005);
        vecs[1]  = mk(3'd0,  1,  2,  3,  0, 6'h20, 16'hBEEF, 26'h3FFFFFF, 32'h00221820);
        vecs[2]  = mk(3'd4,  0,  4, 31, 31, 6'h3F, 16'h0008, 26'h2AAAAAA, 32'h8C040008);
        vecs[3]  = mk(3'd7, 31, 31, 31, 31, 6'h3F, 16'h1234, 26'h0000010, 32'h0C000010);
        vecs[4]  = mk(3'd3,  1,  1, 31, 31, 6'h3F, 16'hFFFF, 26'h2AAAAAA, 32'h1021FFFF);
        vecs[5]  = mk(3'd5,  0,  4, 31, 31, 6'h3F, 16'h0004, 26'h2AAAAAA, 32'hAC040004);
        vecs[6]  = mk(3'd2,  3,  5, 31, 31, 6'h3F, 16'h8000, 26'h2AAAAAA, 32'h28658000);
        vecs[7]  = mk(3'd6, 31, 31, 31, 31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF);
        vecs[8]  = mk(3'd1, 31, 31,  0,  0, 6'h00, 16'hFFFF, 26'h0000000, 32'h23FFFFFF);
        vecs[9]  = mk(3'd0,  0,  2,  4,  3, 6'h00, 16'hFFFF, 26'h3FFFFFF, 32'h000220C0);
        vecs[10] = mk(3'd4, 29,  8, 31, 31, 6'h3F, 16'h0010, 26'h2AAAAAA, 32'h8FA80010);
        vecs[11] = mk(3'd5, 29,  9, 31, 31, 6'h3F, 16'h0014, 26'h2AAAAAA, 32'hAFA90014);
    endtask

    task automatic drive(int idx, logic last);
        req_kind_i   = vecs[idx].kind;
        req_rs_i     = vecs[idx].rs;
        req_rt_i     = vecs[idx].rt;
        req_rd_i     = vecs[idx].rd;
        req_shamt_i  = vecs[idx].sh;
        req_funct_i  = vecs[idx].fn;
        req_imm_i    = vecs[idx].imm;
        req_target_i = vecs[idx].tg;
        req_last_i   = last;
        req_valid_i  = 1'b1;
    endtask

    task automatic send_req(int idx, logic last);
        bit acc = 0;
        drive(idx, last);
        for (int c = 0; c < 50; c++) begin
            acc = req_ready_o;
            @(posedge clk_i); #1;
            if (acc) break;
        end
        req_valid_i = 1'b0;
        req_last_i  = 1'b0;
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL accept vec%0d: accepted=%0d want 1", idx, acc);
        end
    endtask

    task automatic start_session(logic [31:0] base);
        base_addr_i = base;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(string name);
        bit seen = 0;
        for (int c = 0; c < 60; c++) begin
            if (done_o) begin
                seen = 1;
                break;
            end
            @(posedge clk_i); #1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s done timeout: done_o never 1 want 1", name);
        end
        @(posedge clk_i); #1;
        n_vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s after done: done=%b busy=%b want 0 0", name, done_o, busy_o);
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({mem_we_o, req_ready_o, busy_o, done_o} !== 4'b0 || mem_addr_o !== 32'h0 ||
            mem_data_o !== 32'h0 || word_count_o !== 16'h0) begin
            n_err++;
            $display("FAIL reset outputs: we=%b rdy=%b busy=%b done=%b addr=%h data=%h cnt=%h want all 0",
                     mem_we_o, req_ready_o, busy_o, done_o, mem_addr_o, mem_data_o, word_count_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_single_addi();
        mon_addr.delete(); mon_data.delete();
        mem_ready_i = 1'b1;
        start_session(32'h100);
        drive(0, 1'b1);
        n_vec++;
        if (req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL single ready in LOAD: got %b want 1", req_ready_o);
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_last_i  = 1'b0;
        n_vec++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_data_o !== 32'h20220005) begin
            n_err++;
            $display("FAIL single write: we=%b addr=%h data=%h want 1 00000100 20220005",
                     mem_we_o, mem_addr_o, mem_data_o);
        end
        n_vec++;
        if (req_ready_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL single drain: rdy=%b done=%b want 0 0", req_ready_o, done_o);
        end
        @(posedge clk_i); #1;
        n_vec++;
        if (done_o !== 1'b1 || word_count_o !== 16'd1) begin
            n_err++;
            $display("FAIL single done: done=%b cnt=%0d want 1 1", done_o, word_count_o);
        end
        @(posedge clk_i); #1;
        n_vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || mem_addr_o !== 32'h104) begin
            n_err++;
            $display("FAIL single idle: done=%b busy=%b addr=%h want 0 0 00000104",
                     done_o, busy_o, mem_addr_o);
        end
        n_vec++;
        if (mon_addr.size() != 1) begin
            n_err++;
            $display("FAIL single write count: got %0d want 1", mon_addr.size());
        end
    endtask

    task automatic test_mixed_stream();
        mon_addr.delete(); mon_data.delete();
        mem_ready_i = 1'b1;
        start_session(32'h0);
        for (int i = 1; i <= 5; i++) send_req(i, i == 5);
        wait_done("mixed");
        n_vec++;
        if (mon_addr.size() != 5 || word_count_o !== 16'd5) begin
            n_err++;
            $display("FAIL mixed count: writes=%0d cnt=%0d want 5 5", mon_addr.size(), word_count_o);
        end
        for (int i = 0; i < 5 && i < mon_addr.size(); i++) begin
            n_vec++;
            if (mon_addr[i] !== 32'(4 * i) || mon_data[i] !== vecs[i + 1].word) begin
                n_err++;
                $display("FAIL mixed word%0d: addr=%h data=%h want %h %h",
                         i, mon_addr[i], mon_data[i], 32'(4 * i), vecs[i + 1].word);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        bit r;
        mon_addr.delete(); mon_data.delete();
        mem_ready_i = 1'b0;
        start_session(32'h200);
        for (int c = 0; c < 10; c++) begin
            drive(6 + ((acc < 6) ? acc : 5), acc == 5);
            r = req_ready_o;
            @(posedge clk_i); #1;
            if (r) acc++;
            if (mem_we_o) begin
                n_vec++;
                if (mem_addr_o !== 32'h200 || mem_data_o !== vecs[6].word) begin
                    n_err++;
                    $display("FAIL bp hold cyc%0d: addr=%h data=%h want 00000200 %h",
                             c, mem_addr_o, mem_data_o, vecs[6].word);
                end
            end
        end
        n_vec++;
        if (acc != 4 || req_ready_o !== 1'b0 || mem_we_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp full: accepted=%0d rdy=%b we=%b want 4 0 1", acc, req_ready_o, mem_we_o);
        end
        mem_ready_i = 1'b1;
        #1;
        n_vec++;
        if (req_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp pop while full: rdy=%b want 0", req_ready_o);
        end
        for (int c = 0; c < 40 && acc < 6; c++) begin
            drive(6 + acc, acc == 5);
            r = req_ready_o;
            @(posedge clk_i); #1;
            if (r) acc++;
        end
        req_valid_i = 1'b0;
        req_last_i  = 1'b0;
        n_vec++;
        if (acc != 6) begin
            n_err++;
            $display("FAIL bp accepted total: got %0d want 6", acc);
        end
        wait_done("bp");
        n_vec++;
        if (mon_addr.size() != 6 || word_count_o !== 16'd6) begin
            n_err++;
            $display("FAIL bp count: writes=%0d cnt=%0d want 6 6", mon_addr.size(), word_count_o);
        end
        for (int i = 0; i < 6 && i < mon_addr.size(); i++) begin
            n_vec++;
            if (mon_addr[i] !== 32'h200 + 32'(4 * i) || mon_data[i] !== vecs[6 + i].word) begin
                n_err++;
                $display("FAIL bp word%0d: addr=%h data=%h want %h %h", i, mon_addr[i],
                         mon_data[i], 32'h200 + 32'(4 * i), vecs[6 + i].word);
            end
        end
    endtask

    task automatic test_addr_wrap();
        mon_addr.delete(); mon_data.delete();
        mem_ready_i = 1'b1;
        start_session(32'hFFFFFFFC);
        send_req(7, 1'b0);
        send_req(8, 1'b1);
        wait_done("wrap");
        n_vec++;
        if (mon_addr.size() != 2 || mon_addr[0] !== 32'hFFFFFFFC || mon_addr[1] !== 32'h0 ||
            mon_data[0] !== 32'h0BFFFFFF || mon_data[1] !== 32'h23FFFFFF) begin
            n_err++;
            $display("FAIL wrap: n=%0d a0=%h a1=%h d0=%h d1=%h want 2 fffffffc 00000000 0bffffff 23ffffff",
                     mon_addr.size(), mon_addr[0], mon_addr[1], mon_data[0], mon_data[1]);
        end
    endtask

    task automatic test_protocol_edges();
        mon_addr.delete(); mon_data.delete();
        mem_ready_i = 1'b1;
        drive(9, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            n_vec++;
            if (req_ready_o !== 1'b0 || mem_we_o !== 1'b0 || busy_o !== 1'b0) begin
                n_err++;
                $display("FAIL idle valid cyc%0d: rdy=%b we=%b busy=%b want 0 0 0",
                         c, req_ready_o, mem_we_o, busy_o);
            end
        end
        req_valid_i = 1'b0;
        req_last_i  = 1'b0;
        start_session(32'h103);
        n_vec++;
        if (mem_addr_o !== 32'h100 || mon_addr.size() != 0) begin
            n_err++;
            $display("FAIL unaligned base: addr=%h writes=%0d want 00000100 0", mem_addr_o, mon_addr.size());
        end
        send_req(9, 1'b0);
        start_session(32'h500);
        send_req(10, 1'b1);
        wait_done("edges");
        n_vec++;
        if (mon_addr.size() != 2 || mon_addr[0] !== 32'h100 || mon_addr[1] !== 32'h104 ||
            mon_data[0] !== 32'h000220C0 || mon_data[1] !== 32'h8FA80010 || word_count_o !== 16'd2) begin
            n_err++;
            $display("FAIL edges stream: n=%0d a0=%h a1=%h d0=%h d1=%h cnt=%0d want 2 100 104 000220c0 8fa80010 2",
                     mon_addr.size(), mon_addr[0], mon_addr[1], mon_data[0], mon_data[1], word_count_o);
        end
    endtask

    task automatic test_reset_mid_session();
        mon_addr.delete(); mon_data.delete();
        mem_ready_i = 1'b0;
        start_session(32'h300);
        for (int i = 0; i < 3; i++) send_req(i, 1'b0);
        n_vec++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h300 || mem_data_o !== 32'h20220005) begin
            n_err++;
            $display("FAIL pre-reset write: we=%b addr=%h data=%h want 1 00000300 20220005",
                     mem_we_o, mem_addr_o, mem_data_o);
        end
        #2 rst_i = 1'b0;
        #1;
        n_vec++;
        if ({mem_we_o, req_ready_o, busy_o, done_o} !== 4'b0 || mem_addr_o !== 32'h0 ||
            mem_data_o !== 32'h0 || word_count_o !== 16'h0) begin
            n_err++;
            $display("FAIL async reset: we=%b rdy=%b busy=%b done=%b addr=%h data=%h cnt=%h want all 0",
                     mem_we_o, req_ready_o, busy_o, done_o, mem_addr_o, mem_data_o, word_count_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        n_vec++;
        if (busy_o !== 1'b0 || mem_we_o !== 1'b0) begin
            n_err++;
            $display("FAIL post-reset idle: busy=%b we=%b want 0 0", busy_o, mem_we_o);
        end
        start_session(32'h40);
        send_req(4, 1'b1);
        wait_done("post-reset");
        n_vec++;
        if (mon_addr.size() != 1 || mon_addr[0] !== 32'h40 || mon_data[0] !== 32'h1021FFFF ||
            word_count_o !== 16'd1) begin
            n_err++;
            $display("FAIL post-reset session: n=%0d addr=%h data=%h cnt=%0d want 1 00000040 1021ffff 1",
                     mon_addr.size(), mon_addr[0], mon_data[0], word_count_o);
        end
    endtask

    initial begin
        init_vecs();
        test_reset();
        test_single_addi();
        test_mixed_stream();
        test_backpressure();
        test_addr_wrap();
        test_protocol_edges();
        test_reset_mid_session();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
